// File: rtl/if_stage_if.sv
// Signal bundle for the fetch stage.
// Covers the decode-side control inputs, the IF/ID outputs and the instruction ROM port.
// master: the fetch stage. slave: the surrounding decode/ROM environment.
interface if_stage_if #(
  parameter int N_INST_ADDR = 32,
  parameter int N_INST_DATA = 32
);
  logic                   i_stall;
  logic                   i_flush;
  logic [N_INST_ADDR-1:0] i_redirect_pc;
  logic [N_INST_ADDR-1:0] o_rom_addr;
  logic                   o_rom_ce;
  logic [N_INST_DATA-1:0] i_rom_data;
  logic [N_INST_ADDR-1:0] o_id_pc;
  logic [N_INST_DATA-1:0] o_id_inst;
  logic                   o_id_valid;

  modport master (
    input  i_stall, i_flush, i_redirect_pc, i_rom_data,
    output o_rom_addr, o_rom_ce, o_id_pc, o_id_inst, o_id_valid
  );

  modport slave (
    output i_stall, i_flush, i_redirect_pc, i_rom_data,
    input  o_rom_addr, o_rom_ce, o_id_pc, o_id_inst, o_id_valid
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Drives a synchronous-read ROM that has 1-cycle read latency.
// A single skid entry catches the response that lands while decode is stalled.
// On release, that entry drains in the same cycle as the next fetch, so no bubble appears.
//
// state   | meaning
// ST_IDLE | in reset or on the first edge out of it, no ROM reads
// ST_RUN  | fetching, one ROM read per non-stalled cycle
module if_stage #(
  parameter int                     N_INST_ADDR = 32,
  parameter int                     N_INST_DATA = 32,
  parameter logic [N_INST_ADDR-1:0] RESET_PC    = '0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  if_stage_if.master bus
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [N_INST_ADDR-1:0] PC_STEP    = N_INST_ADDR'(4);
  localparam logic [N_INST_ADDR-1:0] ALIGN_MASK = ~N_INST_ADDR'(3);

  state_t                 state_q, state_d;
  logic                   rom_ce;

  logic [N_INST_ADDR-1:0] pc_q;
  logic                   rsp_vld_q;
  logic [N_INST_ADDR-1:0] rsp_pc_q;
  logic                   skid_vld_q;
  logic [N_INST_ADDR-1:0] skid_pc_q;
  logic [N_INST_DATA-1:0] skid_inst_q;
  logic                   id_valid_q;
  logic [N_INST_ADDR-1:0] id_pc_q;
  logic [N_INST_DATA-1:0] id_inst_q;

  // Run-state register; reset always returns to idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Start running on the first edge out of reset; read the ROM only when decode is not stalled.
  always_comb begin
    state_d = state_q;
    rom_ce  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  rom_ce  = ~bus.i_stall;
      default: state_d = ST_IDLE;
    endcase
  end

  // PC, in-flight tracking, skid entry and IF/ID register.
  // Priority: reset, then flush, then stall, then normal.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q        <= RESET_PC;
      rsp_vld_q   <= 1'b0;
      rsp_pc_q    <= '0;
      skid_vld_q  <= 1'b0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      id_valid_q  <= 1'b0;
      id_pc_q     <= '0;
      id_inst_q   <= '0;
    end else if (bus.i_flush) begin
      // The response arriving this cycle belongs to the squashed path and is dropped.
      pc_q       <= bus.i_redirect_pc & ALIGN_MASK;
      rsp_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
    end else begin
      rsp_vld_q <= rom_ce;
      if (rom_ce) begin
        pc_q     <= pc_q + PC_STEP;
        rsp_pc_q <= pc_q;
      end
      if (bus.i_stall) begin
        // No ROM read is issued while stalled, so only one response can ever need parking.
        if (rsp_vld_q) begin
          skid_vld_q  <= 1'b1;
          skid_pc_q   <= rsp_pc_q;
          skid_inst_q <= bus.i_rom_data;
        end
      end else if (skid_vld_q) begin
        skid_vld_q <= 1'b0;
        id_valid_q <= 1'b1;
        id_pc_q    <= skid_pc_q;
        id_inst_q  <= skid_inst_q;
      end else if (rsp_vld_q) begin
        id_valid_q <= 1'b1;
        id_pc_q    <= rsp_pc_q;
        id_inst_q  <= bus.i_rom_data;
      end else begin
        id_valid_q <= 1'b0;
        id_pc_q    <= '0;
        id_inst_q  <= '0;
      end
    end
  end

  assign bus.o_rom_addr = pc_q;
  assign bus.o_rom_ce   = rom_ce;
  assign bus.o_id_pc    = id_pc_q;
  assign bus.o_id_inst  = id_inst_q;
  assign bus.o_id_valid = id_valid_q;

endmodule
